// File: rtl/maf_pkg.sv
// Shared types and constants for the moving-average block averager.
package maf_pkg;

    localparam int MAF_DATA_W = 16;

    typedef enum logic [0:0] {ST_FILL, ST_FULL} maf_state_t;

    typedef logic signed [MAF_DATA_W-1:0] maf_sample_t;

endpackage

// File: rtl/maf_sync_fifo.sv
// Synchronous FIFO for window averages. Pointers are one bit wider than the address
// so that full and empty can be told apart.
module maf_sync_fifo
    import maf_pkg::*;
#(
    parameter int WIDTH = MAF_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/maf_block_averager.sv
// Averages non-overlapping windows of 2^LOG2_N samples and buffers the results in a FIFO.
// Define MAF_AVG_ROUND_EN to round half toward +inf instead of truncating toward -inf.
module maf_block_averager
    import maf_pkg::*;
#(
    parameter int DATA_W     = MAF_DATA_W,
    parameter int LOG2_N     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic signed [DATA_W-1:0]        sample_in,
    input  logic                            sample_valid,
    input  logic                            flush,
    output logic signed [DATA_W-1:0]        avg_out,
    output logic                            avg_valid,
    input  logic                            avg_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow
);

    localparam int ACC_W = DATA_W + LOG2_N;

    maf_state_t               state;
    maf_state_t               state_next;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic [LOG2_N-1:0]        cnt;
    logic signed [DATA_W-1:0] avg;
    logic                     accept;
    logic                     complete;
    logic                     drop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [DATA_W-1:0]        fifo_dout;

    assign sum = acc + {{LOG2_N{sample_in[DATA_W-1]}}, sample_in};

`ifdef MAF_AVG_ROUND_EN
    localparam logic [ACC_W:0] RND_BIAS = {{ACC_W{1'b0}}, 1'b1} << (LOG2_N - 1);
    logic signed [ACC_W:0] sum_rnd;
    assign sum_rnd = {sum[ACC_W-1], sum} + RND_BIAS;
    assign avg     = DATA_W'(sum_rnd >>> LOG2_N);
`else
    assign avg = DATA_W'(sum >>> LOG2_N);
`endif

    // A full FIFO only rejects the new average when the consumer is not draining this cycle.
    assign drop = complete && fifo_full && !avg_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FILL: if (drop) state_next = ST_FULL;
            ST_FULL: state_next = ST_FILL;
            default: state_next = ST_FILL;
        endcase
    end

    // Both states accept samples; ST_FULL only marks the cycle after a dropped average.
    always_comb begin
        accept   = sample_valid && !flush;
        complete = accept && (cnt == '1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (flush || complete) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    maf_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (complete),
        .pop   (avg_ready),
        .din   (avg),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign avg_out   = fifo_dout;
    assign avg_valid = !fifo_empty;

endmodule

// File: tb/tb_maf_block_averager.sv
// Directed self-checking bench for maf_block_averager (default parameters, either rounding build).
module tb_maf_block_averager;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [15:0] sample_in = '0;
    logic               sample_valid = 1'b0;
    logic               flush = 1'b0;
    logic signed [15:0] avg_out;
    logic               avg_valid;
    logic               avg_ready = 1'b0;
    logic [2:0]         fifo_level;
    logic               overflow;

    int checks = 0;
    int errors = 0;

    maf_block_averager dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .flush        (flush),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .avg_ready    (avg_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle; outputs are sampled 1 ns after the rising edge.
    task automatic applyStimulus(input int value, input logic valid);
        sample_in    = 16'(value);
        sample_valid = valid;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic feedWindow(input int value);
        for (int i = 0; i < 8; i++) applyStimulus(value, 1'b1);
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int exp_m7, exp_36, exp_m4, exp_max;
        int n_avg, last_avg;

`ifdef MAF_AVG_ROUND_EN
        exp_m7 = -1; exp_36 = 5; exp_m4 = 0; exp_max = 32767;
`else
        exp_m7 = -1; exp_36 = 4; exp_m4 = -1; exp_max = 32767;
`endif

        // Test 1: reset state and a simple window of +100
        doReset();
        checkOutput("rst_valid", int'(avg_valid), 0);
        checkOutput("rst_out", int'(avg_out), 0);
        checkOutput("rst_level", int'(fifo_level), 0);
        checkOutput("rst_ovf", int'(overflow), 0);
        avg_ready = 1'b1;
        for (int i = 0; i < 7; i++) applyStimulus(100, 1'b1);
        checkOutput("t1_valid_early", int'(avg_valid), 0);
        applyStimulus(100, 1'b1);
        checkOutput("t1_valid", int'(avg_valid), 1);
        checkOutput("t1_out", int'(avg_out), 100);
        checkOutput("t1_level", int'(fifo_level), 1);
        applyStimulus(0, 1'b0);
        checkOutput("t1_level_pop", int'(fifo_level), 0);
        checkOutput("t1_valid_pop", int'(avg_valid), 0);
        checkOutput("t1_out_empty", int'(avg_out), 0);
        applyStimulus(0, 1'b0);
        checkOutput("t1_pop_empty", int'(fifo_level), 0);

        // Test 2: rounding/truncation boundaries
        for (int i = 0; i < 7; i++) applyStimulus(-1, 1'b1);
        applyStimulus(0, 1'b1);
        checkOutput("t2_sum_m7", int'(avg_out), exp_m7);
        applyStimulus(0, 1'b0);
        for (int i = 1; i <= 8; i++) applyStimulus(i, 1'b1);
        checkOutput("t2_sum_36", int'(avg_out), exp_36);
        applyStimulus(0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(-1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1);
        checkOutput("t2_sum_m4", int'(avg_out), exp_m4);
        applyStimulus(0, 1'b0);
        feedWindow(-32768);
        checkOutput("t2_min", int'(avg_out), -32768);
        applyStimulus(0, 1'b0);
        feedWindow(32767);
        checkOutput("t2_max", int'(avg_out), exp_max);
        applyStimulus(0, 1'b0);

        // Test 3: sparse valid, one sample every 8th cycle
        n_avg = 0;
        last_avg = 0;
        for (int c = 0; c < 64; c++) begin
            applyStimulus(10 * (c / 8 + 1), (c % 8) == 0);
            if (avg_valid) begin
                n_avg++;
                last_avg = int'(avg_out);
            end
        end
        checkOutput("t3_count", n_avg, 1);
        checkOutput("t3_value", last_avg, 45);
        checkOutput("t3_level", int'(fifo_level), 0);

        // Test 4: backpressure, fifth window dropped
        doReset();
        avg_ready = 1'b0;
        for (int k = 1; k <= 4; k++) feedWindow(k);
        checkOutput("t4_level_full", int'(fifo_level), 4);
        checkOutput("t4_ovf_before", int'(overflow), 0);
        feedWindow(5);
        checkOutput("t4_level", int'(fifo_level), 4);
        checkOutput("t4_ovf", int'(overflow), 1);
        checkOutput("t4_head", int'(avg_out), 1);
        avg_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("t4_drain%0d", k), int'(avg_out), k);
            applyStimulus(0, 1'b0);
        end
        checkOutput("t4_level_end", int'(fifo_level), 0);
        checkOutput("t4_ovf_sticky", int'(overflow), 1);

        // Test 5: window completes on the same edge as a pop from a full FIFO
        doReset();
        avg_ready = 1'b0;
        for (int k = 1; k <= 4; k++) feedWindow(k);
        for (int i = 0; i < 7; i++) applyStimulus(9, 1'b1);
        avg_ready = 1'b1;
        applyStimulus(9, 1'b1);
        avg_ready = 1'b0;
        checkOutput("t5_level", int'(fifo_level), 4);
        checkOutput("t5_ovf", int'(overflow), 0);
        checkOutput("t5_head", int'(avg_out), 2);
        avg_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t5_drain%0d", k), int'(avg_out), (k == 3) ? 9 : k + 2);
            applyStimulus(0, 1'b0);
        end

        // Test 6a: asynchronous reset mid-window discards the partial sum
        for (int i = 0; i < 5; i++) applyStimulus(77, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_async_level", int'(fifo_level), 0);
        reset = 1'b0;
        feedWindow(50);
        checkOutput("t6_reset_avg", int'(avg_out), 50);
        applyStimulus(0, 1'b0);

        // Test 6b: flush discards partial window, FIFO and flush-cycle sample; overflow kept
        avg_ready = 1'b0;
        for (int k = 0; k < 5; k++) feedWindow(3);
        checkOutput("t6_ovf_set", int'(overflow), 1);
        for (int i = 0; i < 5; i++) applyStimulus(77, 1'b1);
        flush = 1'b1;
        applyStimulus(999, 1'b1);
        flush = 1'b0;
        checkOutput("t6_flush_level", int'(fifo_level), 0);
        checkOutput("t6_flush_valid", int'(avg_valid), 0);
        checkOutput("t6_flush_ovf", int'(overflow), 1);
        feedWindow(50);
        checkOutput("t6_flush_avg", int'(avg_out), 50);
        checkOutput("t6_flush_lvl1", int'(fifo_level), 1);
        checkOutput("t6_ovf_end", int'(overflow), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
